// File: rtl/ks_note_sequencer.sv
// Step sequencer feeding the Karplus-Strong voice: plays a loop of stored periods
// at a programmable tempo and emits a pluck pulse at the start of each sounding step.
module ks_note_sequencer #(
  parameter  int NUM_STEPS    = 8,
  parameter  int DATA_WIDTH   = 8,
  parameter  int TEMPO_WIDTH  = 16,
  parameter  int PLUCK_CYCLES = 4,
  localparam int SW           = $clog2(NUM_STEPS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   hold_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic [SW-1:0]          length_i,
  input  logic                   wr_en_i,
  input  logic [SW-1:0]          wr_addr_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic                   pluck_o,
  output logic [SW-1:0]          step_o,
  output logic                   step_strobe_o,
  output logic                   busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [TEMPO_WIDTH-1:0] PLUCK_T = TEMPO_WIDTH'(PLUCK_CYCLES);

  logic [1:0]             state_q,  state_d;
  logic [TEMPO_WIDTH-1:0] tcnt_q,   tcnt_d;
  logic [SW-1:0]          step_q,   step_d;
  logic [DATA_WIDTH-1:0]  period_q, period_d;
  logic                   pluck_q,  pluck_d;
  logic                   strobe_q, strobe_d;
  logic                   busy_q,   busy_d;
  logic                   load_nz_q, load_nz_d;
  logic [DATA_WIDTH-1:0]  mem_q [NUM_STEPS];
  logic [DATA_WIDTH-1:0]  mem_d [NUM_STEPS];

  logic [TEMPO_WIDTH-1:0] teff, pmin, tcnt_inc;
  logic [SW-1:0]          next_step, load_step;
  logic [DATA_WIDTH-1:0]  load_val;
  logic                   load;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    teff      = (tempo_i == '0) ? TEMPO_WIDTH'(1) : tempo_i;
    pmin      = (PLUCK_T < teff) ? PLUCK_T : teff;
    tcnt_inc  = tcnt_q + TEMPO_WIDTH'(1);
    next_step = (step_q >= length_i) ? '0 : step_q + SW'(1);

    mem_d = mem_q;
    if (wr_en_i) mem_d[wr_addr_i] = wr_data_i;

    state_d   = state_q;
    tcnt_d    = tcnt_q;
    step_d    = step_q;
    period_d  = period_q;
    pluck_d   = pluck_q;
    strobe_d  = 1'b0;
    load_nz_d = load_nz_q;
    load      = 1'b0;
    load_step = '0;
    load_val  = '0;

    case (state_q)
      IDLE: begin
        tcnt_d  = '0;
        pluck_d = 1'b0;
        if (enable_i) begin
          state_d = PLAY;
          load    = 1'b1;
        end
      end
      PLAY, HOLD: begin
        if (!enable_i) begin
          state_d = IDLE;
          tcnt_d  = '0;
          pluck_d = 1'b0;
        end else if (hold_i) begin
          state_d = HOLD;
        end else begin
          // Leaving HOLD advances on the same edge, so each held cycle adds exactly one clock.
          state_d = PLAY;
          if (tcnt_q >= teff) begin
            load      = 1'b1;
            load_step = next_step;
          end else begin
            tcnt_d  = tcnt_inc;
            pluck_d = load_nz_q && (tcnt_inc < pmin);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
        pluck_d = 1'b0;
      end
    endcase

    // Loads read the pre-write RAM contents; a same-cycle write shows up on the next visit.
    if (load) begin
      load_val  = mem_q[load_step];
      step_d    = load_step;
      tcnt_d    = '0;
      strobe_d  = 1'b1;
      load_nz_d = (load_val != '0);
      pluck_d   = load_nz_d;
      if (load_nz_d) period_d = load_val;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      step_q    <= '0;
      period_q  <= '0;
      pluck_q   <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      load_nz_q <= 1'b0;
      // NOTE: the step RAM is built from flops and must read zero after reset, so it is cleared here with the rest of the state.
      for (int i = 0; i < NUM_STEPS; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      step_q    <= step_d;
      period_q  <= period_d;
      pluck_q   <= pluck_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      load_nz_q <= load_nz_d;
      mem_q     <= mem_d;
    end
  end

  assign period_o      = period_q;
  assign pluck_o       = pluck_q;
  assign step_o        = step_q;
  assign step_strobe_o = strobe_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: every expected value is hand-derived from the
// step timing rules (teff+1 clock steps, min(PLUCK_CYCLES, teff) pulse, rests keep period).
module tb_ks_note_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i, hold_i, wr_en_i;
  logic [15:0] tempo_i;
  logic [2:0]  length_i, wr_addr_i, step_o;
  logic [7:0]  wr_data_i, period_o;
  logic        pluck_o, step_strobe_o, busy_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // {step, period, strobe, pluck, busy}
  logic [13:0] obs;
  logic [13:0] exp_v;
  assign obs = {step_o, period_o, step_strobe_o, pluck_o, busy_o};

  ks_note_sequencer #(
    .NUM_STEPS(8), .DATA_WIDTH(8), .TEMPO_WIDTH(16), .PLUCK_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .hold_i(hold_i),
    .tempo_i(tempo_i), .length_i(length_i), .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .period_o(period_o),
    .pluck_o(pluck_o), .step_o(step_o), .step_strobe_o(step_strobe_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic write_mem(input int addr, input int data);
    wr_en_i   = 1'b1;
    wr_addr_i = 3'(addr);
    wr_data_i = 8'(data);
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic stop_seq();
    enable_i = 1'b0;
    hold_i   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    exp_v = '0;
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick(2);
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL idle_after_reset: got %h expected %h", obs, exp_v);
    else pass_cnt++;
  endtask

  task automatic test_rest_ram();
    tempo_i  = 16'd3;
    length_i = 3'd3;
    enable_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick(); else tick();
      exp_v = {3'((k / 4) % 4), 8'd0, (k % 4) == 0, 1'b0, 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL rest_ram k=%0d: got %h expected %h", k, obs, exp_v);
      else pass_cnt++;
    end
    stop_seq();
    chk_cnt++;
    if (busy_o !== 1'b0) $display("FAIL rest_stop_busy: got %b expected 0", busy_o);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    int stp [5] = '{0, 1, 2, 3, 0};
    int per [5] = '{20, 24, 24, 30, 20};
    int s;
    write_mem(0, 20);
    write_mem(1, 24);
    write_mem(2, 0);
    write_mem(3, 30);
    tempo_i  = 16'd9;
    length_i = 3'd3;
    enable_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      s = k / 10;
      exp_v = {3'(stp[s]), 8'(per[s]), (k % 10) == 0, ((k % 10) < 4) && (stp[s] != 2), 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL sequence k=%0d: got %h expected %h", k, obs, exp_v);
      else pass_cnt++;
    end
    stop_seq();
  endtask

  task automatic test_fast_tempo();
    int s;
    tempo_i  = 16'd0;
    length_i = 3'd1;
    enable_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      s = (k / 2) % 2;
      exp_v = {3'(s), (s == 0) ? 8'd20 : 8'd24, (k % 2) == 0, (k % 2) == 0, 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL tempo0 k=%0d: got %h expected %h", k, obs, exp_v);
      else pass_cnt++;
    end
    stop_seq();
    tempo_i  = 16'd2;
    enable_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      s = (k / 3) % 2;
      exp_v = {3'(s), (s == 0) ? 8'd20 : 8'd24, (k % 3) == 0, (k % 3) < 2, 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL tempo2 k=%0d: got %h expected %h", k, obs, exp_v);
      else pass_cnt++;
    end
    stop_seq();
  endtask

  task automatic test_hold();
    int n;
    tempo_i  = 16'd9;
    length_i = 3'd3;
    enable_i = 1'b1;
    tick(14);                       // k=13: step 1, tcnt=3
    hold_i = 1'b1;
    for (int h = 0; h < 5; h++) begin
      tick();
      exp_v = {3'd1, 8'd24, 1'b0, 1'b1, 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL hold_frozen h=%0d: got %h expected %h", h, obs, exp_v);
      else pass_cnt++;
    end
    hold_i = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_strobe_o && n < 40);
    chk_cnt++;
    if (3 + 5 + n !== 15) $display("FAIL hold_step_len: got %0d expected 15", 3 + 5 + n);
    else pass_cnt++;
    chk_cnt++;
    if (step_o !== 3'd2) $display("FAIL hold_next_step: got %0d expected 2", step_o);
    else pass_cnt++;
    tick(2);
    hold_i = 1'b1;
    tick(2);
    enable_i = 1'b0;
    tick();
    exp_v = {3'd2, 8'd24, 1'b0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL hold_disable: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    enable_i = 1'b1;
    hold_i   = 1'b0;
    tick();
    exp_v = {3'd0, 8'd20, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL hold_restart: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_write_collision();
    tempo_i  = 16'd9;
    length_i = 3'd3;
    enable_i = 1'b1;
    tick(10);                       // k=9: step 1 loads on the next edge
    wr_en_i   = 1'b1;
    wr_addr_i = 3'd1;
    wr_data_i = 8'd50;
    tick();
    wr_en_i = 1'b0;
    exp_v = {3'd1, 8'd24, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL collide_old: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    tick(40);
    exp_v = {3'd1, 8'd50, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL collide_new: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_length_change();
    write_mem(4, 40);
    write_mem(5, 44);
    tempo_i  = 16'd1;
    length_i = 3'd5;
    enable_i = 1'b1;
    tick(9);                        // k=8: step 4 loads
    exp_v = {3'd4, 8'd40, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL len_step4: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    length_i = 3'd1;
    tick(2);
    exp_v = {3'd0, 8'd20, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL len_wrap: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    tick(2);
    exp_v = {3'd1, 8'd50, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL len_step1: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    tick(2);
    exp_v = {3'd0, 8'd20, 1'b1, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL len_loop: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    stop_seq();
  endtask

  task automatic test_async_reset();
    tempo_i  = 16'd9;
    length_i = 3'd3;
    enable_i = 1'b1;
    tick(3);                        // k=2 of step 0: mid-pluck
    chk_cnt++;
    if (pluck_o !== 1'b1) $display("FAIL pre_reset_pluck: got %b expected 1", pluck_o);
    else pass_cnt++;
    #2;
    rst_ni   = 1'b0;
    enable_i = 1'b0;
    #1;
    exp_v = '0;
    chk_cnt++;
    if (obs !== exp_v) $display("FAIL async_reset: got %h expected %h", obs, exp_v);
    else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tempo_i  = 16'd0;
    length_i = 3'd3;
    enable_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_v = {3'((k / 2) % 4), 8'd0, (k % 2) == 0, 1'b0, 1'b1};
      chk_cnt++;
      if (obs !== exp_v) $display("FAIL ram_cleared k=%0d: got %h expected %h", k, obs, exp_v);
      else pass_cnt++;
    end
    stop_seq();
  endtask

  initial begin
    enable_i  = 1'b0;
    hold_i    = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    tempo_i   = '0;
    length_i  = '0;
    test_reset();
    test_rest_ram();
    test_sequence();
    test_fast_tempo();
    test_hold();
    test_write_collision();
    test_length_change();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
